// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort engine that time-shares one W-bit comparator: load DEPTH words, sort in place, stream out.
// Define CMP_SORT_DESCEND_EN to sort descending (largest word first); ascending otherwise.
module cmp_sort_ctrl #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] pass_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(DEPTH - 2);

  typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] pass_q, pass_d;
  logic          swap_q, swap_d;
  logic [IW-1:0] idx_nx;
  logic [W-1:0]  cmp_a, cmp_b;
  logic          swap_cond;
  logic          wr_en, swap_en;

  assign idx_nx = idx_q + IW'(1);
  assign cmp_a  = mem_q[idx_q];
  assign cmp_b  = mem_q[idx_nx];

  // Strict inequality keeps equal words in place, so the sort is stable.
`ifdef CMP_SORT_DESCEND_EN
  assign swap_cond = (cmp_a < cmp_b);
`else
  assign swap_cond = (cmp_a > cmp_b);
`endif

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    idx_d    = idx_q;
    rd_idx_d = rd_idx_q;
    pass_d   = pass_q;
    swap_d   = swap_q;
    wr_en    = 1'b0;
    swap_en  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = S_SORT;
            wr_idx_d = '0;
            idx_d    = '0;
            pass_d   = '0;
            swap_d   = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      S_SORT: begin
        swap_en = swap_cond;
        if (swap_cond) swap_d = 1'b1;
        if (idx_q == END_IDX) begin
          pass_d = pass_q + IW'(1);
          // Exit on a clean pass (this compare included) or after the last possible pass.
          if (!(swap_q || swap_cond) || (pass_q == END_IDX)) begin
            state_d  = S_OUT;
            rd_idx_d = '0;
          end else begin
            idx_d  = '0;
            swap_d = 1'b0;
          end
        end else begin
          idx_d = idx_nx;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = S_LOAD;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      idx_q    <= '0;
      rd_idx_q <= '0;
      pass_q   <= '0;
      swap_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      idx_q    <= idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      swap_q   <= swap_d;
      if (wr_en) begin
        mem_q[wr_idx_q] <= in_data;
      end else if (swap_en) begin
        mem_q[idx_q]  <= cmp_b;
        mem_q[idx_nx] <= cmp_a;
      end
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_SORT);
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = out_valid ? mem_q[rd_idx_q] : '0;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl at DEPTH=4, W=4; expected results hand-derived from bubble-sort rules.
module tb_cmp_sort_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [1:0] pass_count;

  int n_checks = 0;
  int n_fail   = 0;

  cmp_sort_ctrl #(.DEPTH(4), .W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .pass_count (pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pack4(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic load4(input logic [15:0] din);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = din[i*4 +: 4];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_sort(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // mode 0: out_ready held high; mode 1: stalled 5 cycles, then toggled
  task automatic drain(input string tag, input int mode, input logic [15:0] exp_out,
                       output logic [15:0] got, output int cyc);
    int n;
    n   = 0;
    cyc = 0;
    got = '1;
    while (n < 4 && cyc < 100) begin
      if (mode == 0) out_ready = 1'b1;
      else           out_ready = (cyc >= 5) && (((cyc - 5) % 2) == 0);
      if (mode == 1 && cyc < 5) chk({tag, "_hold"}, 32'(out_data), 32'(exp_out[3:0]));
      if (out_valid && out_ready) begin
        got[n*4 +: 4] = out_data;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_count"}, n, 4);
  endtask

  task automatic run_batch(input string tag, input logic [15:0] din, input int exp_busy,
                           input int exp_pc, input logic [15:0] exp_out, input int mode);
    int cyc;
    int dcyc;
    logic [15:0] got;
    load4(din);
    wait_sort(cyc);
    chk({tag, "_busy"}, cyc, exp_busy);
    chk({tag, "_pass"}, 32'(pass_count), exp_pc);
    chk({tag, "_ovld"}, 32'(out_valid), 1);
    drain(tag, mode, exp_out, got, dcyc);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got[i*4 +: 4]), 32'(exp_out[i*4 +: 4]));
    if (mode == 0) chk({tag, "_ocyc"}, dcyc, 4);
    chk({tag, "_irdy"}, 32'(in_ready), 1);
    chk({tag, "_odone"}, 32'(out_valid), 0);
    chk({tag, "_pass_hold"}, 32'(pass_count), exp_pc);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ovld", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pass", 32'(pass_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_irdy", 32'(in_ready), 1);

`ifdef CMP_SORT_DESCEND_EN
    run_batch("desc", pack4(3, 1, 2, 0), 6, 2, pack4(3, 2, 1, 0), 0);
    run_batch("desc_early", pack4(3, 2, 1, 0), 3, 1, pack4(3, 2, 1, 0), 0);
`else
    run_batch("asc", pack4(3, 1, 2, 0), 9, 3, pack4(0, 1, 2, 3), 0);
    run_batch("early", pack4(0, 1, 2, 3), 3, 1, pack4(0, 1, 2, 3), 0);
    // pass 2 still swaps, so a third clean pass is needed before exit
    run_batch("dup", pack4(5, 5, 2, 5), 9, 3, pack4(2, 5, 5, 5), 0);
    run_batch("bp", pack4(9, 4, 7, 1), 9, 3, pack4(1, 4, 7, 9), 1);
`endif

    load4(pack4(3, 1, 2, 0));
    chk("mid_busy1", 32'(busy), 1);
    @(negedge clk);
    chk("mid_busy2", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ovld", 32'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("mid_no_out", cyc, 0);
    chk("mid_pass_clr", 32'(pass_count), 0);
`ifdef CMP_SORT_DESCEND_EN
    run_batch("reload", pack4(8, 6, 4, 2), 3, 1, pack4(8, 6, 4, 2), 0);
`else
    run_batch("reload", pack4(8, 6, 4, 2), 9, 3, pack4(2, 4, 6, 8), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
